// File: rtl/display_decoder.sv
// Recovers digits from a multiplexed, active-low 7-segment scan and commits a
// frame once all four anode slots have been sampled in any order.
module display_decoder (
   input  logic        clk_500Hz,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [13:0] number,
   output logic [15:0] digits,
   output logic        frame_valid,
   output logic        numeric,
   output logic        stable,
   output logic        anode_err
);

   logic [15:0] cap_q, cap_d;
   logic [3:0]  seen_q, seen_d;
   logic        hasCommit_q, hasCommit_d;
   logic [13:0] number_q, number_d;
   logic [15:0] digits_q, digits_d;
   logic        frameValid_q, frameValid_d;
   logic        numeric_q, numeric_d;
   logic        stable_q, stable_d;
   logic        anodeErr_q, anodeErr_d;

   logic [3:0]  glyph;
   logic [3:0]  slotHot;
   logic        illegal;
   logic [15:0] capNext;
   logic [3:0]  seenNext;
   logic        commit;
   logic        allNum;
   logic [13:0] value;

   // Active-low glyph table; an all-dark digit is reported as blank (E).
   always_comb begin
      glyph = 4'hF;
      case (seg)
         7'b1000000: glyph = 4'd0;
         7'b1111001: glyph = 4'd1;
         7'b0100100: glyph = 4'd2;
         7'b0110000: glyph = 4'd3;
         7'b0011001: glyph = 4'd4;
         7'b0010010: glyph = 4'd5;
         7'b0000010: glyph = 4'd6;
         7'b1111000: glyph = 4'd7;
         7'b0000000: glyph = 4'd8;
         7'b0011000: glyph = 4'd9;
         7'b1111111: glyph = 4'hE;
         default:    glyph = 4'hF;
      endcase
   end

   always_comb begin
      slotHot = 4'b0000;
      illegal = 1'b0;
      case (an)
         4'b1110: slotHot = 4'b1000;
         4'b1101: slotHot = 4'b0100;
         4'b1011: slotHot = 4'b0010;
         4'b0111: slotHot = 4'b0001;
         4'b1111: slotHot = 4'b0000;
         default: illegal = 1'b1;
      endcase
   end

   // The completing sample is folded into capNext so the commit sees it directly.
   always_comb begin
      capNext = cap_q;
      for (int i = 0; i < 4; i++) begin
         if (slotHot[i]) capNext[i*4 +: 4] = glyph;
      end
      seenNext = seen_q | slotHot;
      commit   = (slotHot != 4'b0000) && (seenNext == 4'b1111);
      allNum   = (capNext[15:12] <= 4'd9) && (capNext[11:8] <= 4'd9) &&
                 (capNext[7:4] <= 4'd9) && (capNext[3:0] <= 4'd9);
      value    = 14'(capNext[15:12]) * 14'd1000 + 14'(capNext[11:8]) * 14'd100 +
                 14'(capNext[7:4]) * 14'd10 + 14'(capNext[3:0]);
   end

   always_comb begin
      cap_d        = capNext;
      seen_d       = commit ? 4'b0000 : seenNext;
      hasCommit_d  = hasCommit_q | commit;
      digits_d     = commit ? capNext : digits_q;
      numeric_d    = commit ? allNum : numeric_q;
      number_d     = (commit && allNum) ? value : number_q;
      stable_d     = commit ? (hasCommit_q && (capNext == digits_q)) : stable_q;
      frameValid_d = commit;
      anodeErr_d   = illegal;
   end

   always_ff @(posedge clk_500Hz) begin
      if (rst) begin
         cap_q        <= '0;
         seen_q       <= '0;
         hasCommit_q  <= 1'b0;
         number_q     <= '0;
         digits_q     <= '0;
         frameValid_q <= 1'b0;
         numeric_q    <= 1'b0;
         stable_q     <= 1'b0;
         anodeErr_q   <= 1'b0;
      end else begin
         cap_q        <= cap_d;
         seen_q       <= seen_d;
         hasCommit_q  <= hasCommit_d;
         number_q     <= number_d;
         digits_q     <= digits_d;
         frameValid_q <= frameValid_d;
         numeric_q    <= numeric_d;
         stable_q     <= stable_d;
         anodeErr_q   <= anodeErr_d;
      end
   end

   assign number      = number_q;
   assign digits      = digits_q;
   assign frame_valid = frameValid_q;
   assign numeric     = numeric_q;
   assign stable      = stable_q;
   assign anode_err   = anodeErr_q;

endmodule

// File: tb/tb_display_decoder.sv
// Scoreboard bench for display_decoder: every sample pushes the expected
// registered outputs, which the scenario task pops and compares one edge later.
module tb_display_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = 7'h7F;
   logic [3:0]  an  = 4'hF;
   logic [13:0] number;
   logic [15:0] digits;
   logic        frame_valid, numeric, stable, anode_err;

   typedef struct packed {
      logic        fv;
      logic        ae;
      logic        nm;
      logic        st;
      logic [13:0] num;
      logic [15:0] dig;
   } exp_t;

   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0011000};
   localparam logic [3:0] AN_SLOT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   exp_t        expQ[$];
   exp_t        mExp;
   logic [3:0]  mSeen;
   logic [15:0] mCap;
   logic        mHad;
   logic [33:0] obsBits;
   int          vectors = 0;
   int          miscompares = 0;

   assign obsBits = {frame_valid, anode_err, numeric, stable, number, digits};

   display_decoder dut (
      .clk_500Hz  (clk),
      .rst        (rst),
      .seg        (seg),
      .an         (an),
      .number     (number),
      .digits     (digits),
      .frame_valid(frame_valid),
      .numeric    (numeric),
      .stable     (stable),
      .anode_err  (anode_err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] glyphOf(input logic [6:0] s);
      if (s == 7'h7F) return 4'hE;
      for (int d = 0; d < 10; d++) if (SEG[d] == s) return 4'(d);
      return 4'hF;
   endfunction

   // Reference behaviour of one clock edge, written from the frame's point of view.
   task automatic modelSample(input logic r, input logic [3:0] a, input logic [6:0] s);
      int slot;
      int val;
      logic allNum;
      if (r) begin
         mExp = '0; mSeen = '0; mCap = '0; mHad = 1'b0;
         return;
      end
      mExp.fv = 1'b0;
      mExp.ae = 1'b0;
      slot = -1;
      for (int k = 0; k < 4; k++) if (a == AN_SLOT[k]) slot = k;
      if (slot < 0 && a != 4'b1111) mExp.ae = 1'b1;
      if (slot >= 0) begin
         mCap[slot*4 +: 4] = glyphOf(s);
         mSeen[slot] = 1'b1;
         if (mSeen == 4'hF) begin
            allNum = 1'b1;
            val = 0;
            for (int k = 3; k >= 0; k--) begin
               if (mCap[k*4 +: 4] > 4'd9) allNum = 1'b0;
               val = val * 10 + int'(mCap[k*4 +: 4]);
            end
            mExp.fv  = 1'b1;
            mExp.st  = mHad && (mCap == mExp.dig);
            mExp.dig = mCap;
            mExp.nm  = allNum;
            if (allNum) mExp.num = val[13:0];
            mHad  = 1'b1;
            mSeen = '0;
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] a, input logic [6:0] s);
      rst = r; an = a; seg = s;
      modelSample(r, a, s);
      expQ.push_back(mExp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 4'b1110, SEG[i]);
         e = expQ.pop_front();
         vectors++;
         if (obsBits !== e || obsBits !== 34'd0) begin
            miscompares++;
            $display("[TB] FAIL reset[%0d]: got %h expected %h", i, obsBits, e);
         end
      end
   endtask

   task automatic scanFrame(input string name, input int d3, input int d2, input int d1, input int d0);
      exp_t e;
      int dv[4];
      dv = '{d0, d1, d2, d3};
      for (int k = 3; k >= 0; k--) begin
         applyStimulus(1'b0, AN_SLOT[k], (dv[k] < 10) ? SEG[dv[k]] : 7'b1110111);
         e = expQ.pop_front();
         vectors++;
         if (obsBits !== e) begin
            miscompares++;
            $display("[TB] FAIL %s slot%0d: got %h expected %h", name, k, obsBits, e);
         end
      end
   endtask

   task automatic test_basic();
      scanFrame("basic", 1, 2, 3, 4);
      vectors++;
      if (frame_valid !== 1'b1 || number !== 14'd1234 || digits !== 16'h1234 ||
          numeric !== 1'b1 || stable !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_commit: got fv=%b num=%0d dig=%h nm=%b st=%b expected 1 1234 1234 1 0",
                  frame_valid, number, digits, numeric, stable);
      end
      applyStimulus(1'b0, 4'b1111, 7'h7F);
      void'(expQ.pop_front());
      vectors++;
      if (frame_valid !== 1'b0 || number !== 14'd1234) begin
         miscompares++;
         $display("[TB] FAIL basic_pulse: got fv=%b num=%0d expected 0 1234", frame_valid, number);
      end
   endtask

   task automatic test_stable();
      scanFrame("stable_rep", 1, 2, 3, 4);
      vectors++;
      if (frame_valid !== 1'b1 || stable !== 1'b1 || number !== 14'd1234) begin
         miscompares++;
         $display("[TB] FAIL stable_rep: got fv=%b st=%b num=%0d expected 1 1 1234", frame_valid, stable, number);
      end
      scanFrame("stable_new", 1, 2, 3, 5);
      vectors++;
      if (stable !== 1'b0 || number !== 14'd1235) begin
         miscompares++;
         $display("[TB] FAIL stable_new: got st=%b num=%0d expected 0 1235", stable, number);
      end
   endtask

   task automatic test_nonnumeric();
      scanFrame("nonnum", 10, 0, 0, 0);
      vectors++;
      if (digits !== 16'hF000 || numeric !== 1'b0 || number !== 14'd1235 || frame_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL nonnum: got dig=%h nm=%b num=%0d fv=%b expected F000 0 1235 1",
                  digits, numeric, number, frame_valid);
      end
   endtask

   task automatic test_anode();
      exp_t e;
      logic [3:0] seqAn [6] = '{4'b0111, 4'b0000, 4'b1111, 4'b1011, 4'b1101, 4'b1110};
      logic [1:0] wantAe [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, seqAn[i], SEG[i % 10]);
         e = expQ.pop_front();
         vectors++;
         if (obsBits !== e || {frame_valid, anode_err} !== wantAe[i]) begin
            miscompares++;
            $display("[TB] FAIL anode step %0d: got %h expected %h", i, obsBits, e);
         end
      end
   endtask

   task automatic test_overwrite();
      exp_t e;
      int commits = 0;
      logic [3:0] seqAn [5] = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
      int seqD [5] = '{3, 9, 8, 7, 6};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, seqAn[i], SEG[seqD[i]]);
         e = expQ.pop_front();
         if (frame_valid === 1'b1) commits++;
         vectors++;
         if (obsBits !== e) begin
            miscompares++;
            $display("[TB] FAIL overwrite step %0d: got %h expected %h", i, obsBits, e);
         end
      end
      vectors++;
      if (commits != 1 || digits !== 16'h9876 || number !== 14'd9876) begin
         miscompares++;
         $display("[TB] FAIL overwrite_commit: got commits=%0d dig=%h expected 1 9876", commits, digits);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, AN_SLOT[3 - i], SEG[7 + i]);
         void'(expQ.pop_front());
      end
      applyStimulus(1'b1, 4'b1110, SEG[5]);
      e = expQ.pop_front();
      vectors++;
      if (obsBits !== 34'd0 || obsBits !== e) begin
         miscompares++;
         $display("[TB] FAIL midreset: got %h expected 0", obsBits);
      end
      for (int k = 3; k >= 0; k--) begin
         applyStimulus(1'b0, AN_SLOT[k], SEG[k]);
         e = expQ.pop_front();
         vectors++;
         if (obsBits !== e || frame_valid !== (k == 0)) begin
            miscompares++;
            $display("[TB] FAIL midreset slot%0d: got %h expected %h", k, obsBits, e);
         end
      end
      vectors++;
      if (number !== 14'd3210 || stable !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_commit: got num=%0d st=%b expected 3210 0", number, stable);
      end
      // Random scan traffic, including illegal anodes, stray segments and resets.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] a;
         logic [6:0] s;
         int pick;
         pick = $urandom_range(0, 9);
         a = (pick < 7) ? AN_SLOT[pick % 4] : (pick == 7) ? 4'b1111 : 4'($urandom_range(0, 15));
         pick = $urandom_range(0, 12);
         s = (pick < 10) ? SEG[pick] : (pick == 10) ? 7'h7F : 7'($urandom_range(0, 127));
         applyStimulus(($urandom_range(0, 49) == 0), a, s);
         e = expQ.pop_front();
         vectors++;
         if (obsBits !== e) begin
            miscompares++;
            $display("[TB] FAIL random step %0d: got %h expected %h", i, obsBits, e);
         end
      end
   endtask

   initial begin
      mExp = '0; mSeen = '0; mCap = '0; mHad = 1'b0;
      test_reset();
      test_basic();
      test_stable();
      test_nonnumeric();
      test_anode();
      test_overwrite();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_decoder.md
DISPLAY_DECODER -- requirements
Module: display_decoder

Interface
REQ-001 Parameters: none; digit encodings, scan order and output widths are fixed by this document.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk_500Hz  input  1  sampling clock, same domain as the display scan clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 seg  input  7  segment lines, active low, bit6..bit0 = g..a.
REQ-006 an  input  4  anode lines, active low.
REQ-007 number  output  14  binary value of the last committed all-numeric frame, 0..9999.
REQ-008 digits  output  16  last committed glyph codes; [15:12] leftmost.
REQ-009 frame_valid  output  1  one-cycle pulse on each commit.
REQ-010 numeric  output  1  last committed frame contained four decimal digits.
REQ-011 stable  output  1  last two committed frames had identical digits.
REQ-012 anode_err  output  1  one-cycle pulse on an illegal anode pattern.

Function
REQ-013 Glyph decode of seg: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 1111111->4'hE (blank), any other pattern->4'hF (non-numeric).
REQ-014 Slot map for legal anode patterns: an=1110->slot3 (leftmost, thousands), 1101->slot2, 1011->slot1, 0111->slot0 (ones).
REQ-015 Each edge with a legal anode pattern writes the decoded code into that slot's capture register and sets that slot's seen bit.
REQ-016 A repeated slot before frame completion overwrites that slot's capture register; the seen mask is unchanged; no commit occurs.
REQ-017 an=1111 is idle: no capture, no error.
REQ-018 Any other anode pattern (0000, or two or more zeros): no capture; anode_err high in the following cycle only; the seen mask is retained.
REQ-019 Commit: on the edge whose sample makes the seen mask 4'b1111, update digits from the capture registers including the completing sample, update numeric, number and stable, clear the seen mask to 0, and assert frame_valid for exactly the next cycle.
REQ-020 The completing sample is not counted toward the next frame.
REQ-021 numeric = 1 at commit when all four codes are <= 9; otherwise numeric = 0.
REQ-022 On a commit with numeric = 1, number = d3*1000 + d2*100 + d1*10 + d0 (14 bits, no overflow possible).
REQ-023 On a commit with numeric = 0, number holds its previous value.
REQ-024 stable = 1 at commit when at least one earlier commit exists since reset and the new digits equal the previously committed digits; otherwise stable = 0.
REQ-025 stable holds its value between commits.
REQ-026 Scan order is not assumed: any order of the four slots completes a frame.
REQ-027 Outputs are registered; there are no combinational paths from seg or an to any output.

Reset
REQ-028 While rst=1 at an edge: number=0, digits=16'h0000, frame_valid=0, numeric=0, stable=0, anode_err=0, seen mask=0, capture registers=0, and the "earlier commit exists" flag is cleared.
REQ-029 A reset mid-frame discards all partial captures; the next frame requires four fresh slots.

Verification
REQ-030 Scan an 1110/1101/1011/0111 with seg for 1,2,3,4 -> one cycle after the 4th sample: frame_valid=1 for one cycle, number=1234, digits=16'h1234, numeric=1, stable=0.
REQ-031 Repeat the 1234 frame -> second commit gives stable=1 and number=1234; then a frame 1235 -> stable=0, number=1235.
REQ-032 Frame with slot3 seg=1110111 and the other slots showing 0 -> digits=16'hF000, numeric=0, number keeps its prior value.
REQ-033 Samples slot0, then an=0000, then an=1111, then slots 1, 2, 3 -> anode_err single pulse after 0000; commit after the slot3 sample; no commit earlier.
REQ-034 Slot3, slot3 (new value 9), slot2, slot1, slot0 -> exactly one commit with d3=9.
REQ-035 rst asserted after two slots captured, then released and three slots sampled -> no frame_valid; after the 4th slot -> commit; all outputs 0 during reset.
